// File: rtl/snake_body_pkg.sv
// Shared definitions for the snake body controller: state encoding,
// null coordinate and default geometry.
package snake_body_pkg;

  localparam int XW_DEF       = 7;
  localparam int DEPTH_DEF    = 256;
  localparam int AW_DEF       = 8;
  localparam int INIT_LEN_DEF = 3;

  // Coordinate returned for reads beyond the current body length
  localparam int NULL_COORD   = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_SCAN  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/snake_body_ram.sv
// Single-port body-segment RAM, synchronous read with one-cycle latency.
// Contents are intentionally not cleared by reset.
module snake_body_ram #(
  parameter int W     = 14,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write when enabled; always register the addressed word for reading
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake body controller: circular-queue body storage, per-move
// self-collision scan / head push / tail drop, and an idle-time read
// port for the renderer.
module snake_body_ctrl
  import snake_body_pkg::*;
#(
  parameter int XW       = XW_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AW       = AW_DEF,
  parameter int INIT_LEN = INIT_LEN_DEF
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic          i_Init,
  input  logic          i_Start,
  input  logic [XW-1:0] i_Head_x,
  input  logic [XW-1:0] i_Head_y,
  input  logic          i_Grow,
  output logic          o_Busy,
  output logic          o_Done,
  output logic          o_Hit,
  output logic [AW:0]   o_Len,
  input  logic          i_Rd_req,
  input  logic [AW-1:0] i_Rd_idx,
  output logic          o_Rd_ack,
  output logic [XW-1:0] o_Rd_x,
  output logic [XW-1:0] o_Rd_y
);

  state_t         state;
  logic [AW-1:0]  head_ptr;
  logic [XW-1:0]  new_x;
  logic [XW-1:0]  new_y;
  logic           grow_eff;
  logic [AW:0]    cnt;
  logic [AW:0]    cmp_total;
  logic           cmp_valid;
  logic           hit_flag;
  logic           rd_valid;

  logic           start_grow;
  logic [AW:0]    start_cmp;
  logic           accept_rd;
  logic           seg_match;

  logic           ram_we;
  logic [AW-1:0]  ram_addr;
  logic [2*XW-1:0] ram_wdata;
  logic [2*XW-1:0] ram_rdata;

  snake_body_ram #(
    .W     (2*XW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (i_Clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Move parameters derived from the current length at acceptance time;
  // the departing tail is not scanned unless the snake grows
  always_comb begin
    start_grow = i_Grow && (o_Len < (AW+1)'(DEPTH));
    if (start_grow) begin
      start_cmp = o_Len;
    end else if (o_Len == (AW+1)'(0)) begin
      start_cmp = (AW+1)'(0);
    end else begin
      start_cmp = o_Len - (AW+1)'(1);
    end
  end

  // Renderer acceptance, and comparison of the segment read last cycle
  always_comb begin
    accept_rd = (state == ST_IDLE) && !i_Init && !i_Start && i_Rd_req;
    seg_match = cmp_valid && (ram_rdata == {new_x, new_y});
  end

  // RAM port steering: init writes, scan reads, head write, else renderer
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = head_ptr + i_Rd_idx;
    ram_wdata = {new_x, new_y};
    case (state)
      ST_INIT: begin
        ram_we    = 1'b1;
        ram_addr  = cnt[AW-1:0];
        ram_wdata = {new_x + XW'(cnt), new_y};
      end
      ST_SCAN: begin
        ram_addr = head_ptr + cnt[AW-1:0];
      end
      ST_WRITE: begin
        ram_we   = ~hit_flag;
        ram_addr = head_ptr - AW'(1);
      end
      default: begin
        ram_we = 1'b0;
      end
    endcase
  end

  // Sequencer: init load, move scan/write, done pulse, renderer ack
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state     <= ST_IDLE;
      head_ptr  <= '0;
      new_x     <= '0;
      new_y     <= '0;
      grow_eff  <= 1'b0;
      cnt       <= '0;
      cmp_total <= '0;
      cmp_valid <= 1'b0;
      hit_flag  <= 1'b0;
      rd_valid  <= 1'b0;
      o_Busy    <= 1'b0;
      o_Done    <= 1'b0;
      o_Hit     <= 1'b0;
      o_Len     <= '0;
      o_Rd_ack  <= 1'b0;
    end else begin
      o_Done    <= 1'b0;
      cmp_valid <= 1'b0;
      o_Rd_ack  <= accept_rd;
      rd_valid  <= ({1'b0, i_Rd_idx} < o_Len);
      if (seg_match) begin
        hit_flag <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (i_Init) begin
            new_x    <= i_Head_x;
            new_y    <= i_Head_y;
            head_ptr <= '0;
            cnt      <= '0;
            hit_flag <= 1'b0;
            o_Hit    <= 1'b0;
            o_Busy   <= 1'b1;
            state    <= ST_INIT;
          end else if (i_Start) begin
            new_x     <= i_Head_x;
            new_y     <= i_Head_y;
            grow_eff  <= start_grow;
            cmp_total <= start_cmp;
            cnt       <= '0;
            hit_flag  <= 1'b0;
            o_Hit     <= 1'b0;
            o_Busy    <= 1'b1;
            state     <= (start_cmp == (AW+1)'(0)) ? ST_WAIT : ST_SCAN;
          end
        end
        ST_INIT: begin
          cnt <= cnt + (AW+1)'(1);
          if (cnt == (AW+1)'(INIT_LEN - 1)) begin
            o_Len  <= (AW+1)'(INIT_LEN);
            o_Done <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_SCAN: begin
          cmp_valid <= 1'b1;
          cnt       <= cnt + (AW+1)'(1);
          if (cnt == cmp_total - (AW+1)'(1)) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          if (!hit_flag) begin
            head_ptr <= head_ptr - AW'(1);
            if (grow_eff || (o_Len == (AW+1)'(0))) begin
              o_Len <= o_Len + (AW+1)'(1);
            end
          end
          o_Hit  <= hit_flag;
          o_Done <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          o_Busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          o_Busy <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_Rd_x = (o_Rd_ack && rd_valid) ? ram_rdata[2*XW-1:XW] : XW'(NULL_COORD);
  assign o_Rd_y = (o_Rd_ack && rd_valid) ? ram_rdata[XW-1:0]    : XW'(NULL_COORD);

endmodule
